// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage cache access sequencer.
//   mem_state_t : sequencer states (IDLE, REQ, WAIT)
//   BYTE_LANES  : byte lanes per cache word (lane 0 = bits [7:0])
//   is_aligned  : word accesses must sit on a 4-byte boundary; byte accesses are always aligned
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

    localparam int BYTE_LANES = 4;
    localparam int LANE_BITS  = $clog2(BYTE_LANES);

    function automatic logic is_aligned(input logic word_access, input logic [LANE_BITS-1:0] byte_off);
        return !word_access || (byte_off == '0);
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: purely combinational byte-lane handling for the data-cache port.
//   i_is_word     in   1   1 = word access, 0 = byte access
//   i_byte_off    in   2   byte offset within the word (alu_result[1:0])
//   i_store_data  in   32  store operand; byte stores use [7:0]
//   i_load_word   in   32  word returned by the cache
//   o_byte_en     out  4   byte enables (all lanes for word, one-hot for byte)
//   o_write_data  out  32  write data; a byte store is replicated into every lane
//   o_load_data   out  32  load result; byte loads are zero-extended from the addressed lane
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic                  i_is_word,
    input  logic [LANE_BITS-1:0]  i_byte_off,
    input  logic [31:0]           i_store_data,
    input  logic [31:0]           i_load_word,
    output logic [BYTE_LANES-1:0] o_byte_en,
    output logic [31:0]           o_write_data,
    output logic [31:0]           o_load_data
);

    logic [31:0] w_lane_shifted;

    // Bring the addressed lane down to bits [7:0].
    assign w_lane_shifted = i_load_word >> {i_byte_off, 3'b000};

    always_comb begin
        if (i_is_word) begin
            o_byte_en    = '1;
            o_write_data = i_store_data;
            o_load_data  = i_load_word;
        end else begin
            o_byte_en    = BYTE_LANES'(1) << i_byte_off;
            // Replication lets the cache take the byte from whichever lane is enabled.
            o_write_data = {BYTE_LANES{i_store_data[7:0]}};
            o_load_data  = {24'b0, w_lane_shifted[7:0]};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage cache access sequencer sitting after the EX/MEM register.
// Converts one latched load/store into a single data-cache transaction, stalls the
// front of the pipe until the cache completes, and hands aligned load data to MEM/WB.
// Misaligned word accesses and cache timeouts raise a one-cycle mem_fault and retire.
//   clk, rst_b       clock / synchronous active-low reset
//   is_mem_inst      EX/MEM: load or store present
//   mem_write_en     EX/MEM: 1 = store, 0 = load
//   is_word          EX/MEM: 1 = word, 0 = byte
//   halted           EX/MEM: halt marker, suppresses any access
//   alu_result       EX/MEM: effective byte address
//   read_data_2      EX/MEM: store data
//   cache_ready      cache accepts the request this cycle
//   cache_done       cache completion this cycle
//   cache_rdata      cache read word
//   cache_req/we/addr/wdata/be   request to the cache
//   mem_stall        freeze IF..EX/MEM
//   mem_rdata        load result for MEM/WB
//   mem_fault        one-cycle pulse: misaligned word access or timeout
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        is_mem_inst,
    input  logic        mem_write_en,
    input  logic        is_word,
    input  logic        halted,
    input  logic [31:0] alu_result,
    input  logic [31:0] read_data_2,
    input  logic        cache_ready,
    input  logic        cache_done,
    input  logic [31:0] cache_rdata,
    output logic        cache_req,
    output logic        cache_we,
    output logic [31:0] cache_addr,
    output logic [31:0] cache_wdata,
    output logic [3:0]  cache_be,
    output logic        mem_stall,
    output logic [31:0] mem_rdata,
    output logic        mem_fault
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_t       r_state;
    mem_state_t       w_next_state;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_rdata;

    logic        w_active;
    logic        w_aligned;
    logic        w_go;
    logic        w_busy;
    logic        w_complete;
    logic        w_timeout;
    logic [31:0] w_load_data;
    logic [31:0] w_rdata;

    mem_lane_align u_lane_align (
        .i_is_word    (is_word),
        .i_byte_off   (alu_result[1:0]),
        .i_store_data (read_data_2),
        .i_load_word  (cache_rdata),
        .o_byte_en    (cache_be),
        .o_write_data (cache_wdata),
        .o_load_data  (w_load_data)
    );

    assign w_active  = is_mem_inst && !halted;
    assign w_aligned = is_aligned(is_word, alu_result[1:0]);
    assign w_go      = w_active && w_aligned;
    assign w_busy    = (r_state == REQ) || (r_state == WAIT);

    // Completion also covers the cache accepting and finishing in the same REQ cycle;
    // the stall must drop then too, otherwise the held instruction would be re-issued.
    assign w_complete = cache_done && ((r_state == WAIT) || ((r_state == REQ) && cache_ready));

    // A completion landing on the last allowed cycle is honoured rather than discarded.
    assign w_timeout = w_busy && (r_count == CNT_LAST) && !w_complete;

    assign cache_we   = mem_write_en;
    assign cache_addr = {alu_result[31:2], 2'b00};

    // Fresh lane data in a load's completion cycle, otherwise the held copy.
    assign w_rdata   = (w_complete && !mem_write_en) ? w_load_data : r_rdata;
    assign mem_rdata = w_rdata;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        w_next_state = r_state;
        cache_req    = 1'b0;
        mem_stall    = w_go && !w_complete && !w_timeout;
        mem_fault    = w_timeout;

        unique case (r_state)
            IDLE: begin
                if (w_go) begin
                    w_next_state = REQ;
                end
                // Misaligned word: no request, instruction retires as a no-op.
                mem_fault = w_active && !w_aligned;
            end
            REQ: begin
                cache_req = !w_timeout;
                if (w_timeout || (cache_ready && cache_done)) begin
                    w_next_state = IDLE;
                end else if (cache_ready) begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (w_timeout || cache_done) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_b) begin
            r_state <= IDLE;
            r_count <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next_state;
            // The counter runs while a transaction is outstanding and is cleared in IDLE,
            // so the first REQ cycle always sees zero.
            r_count <= w_busy ? r_count + 1'b1 : '0;
            r_rdata <= w_rdata;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit. The driver issues one memory instruction at a
// time, playing the cache with chosen ready/done delays, and pushes the expected cache
// request and the expected retirement (fault flag, load result) into queues. A monitor
// pops and compares whenever the DUT hands a request to the cache or retires.
module tb_mem_access_unit;

    localparam int T = 8;

    logic        clk;
    logic        rst_b;
    logic        is_mem_inst;
    logic        mem_write_en;
    logic        is_word;
    logic        halted;
    logic [31:0] alu_result;
    logic [31:0] read_data_2;
    logic        cache_ready;
    logic        cache_done;
    logic [31:0] cache_rdata;
    logic        cache_req;
    logic        cache_we;
    logic [31:0] cache_addr;
    logic [31:0] cache_wdata;
    logic [3:0]  cache_be;
    logic        mem_stall;
    logic [31:0] mem_rdata;
    logic        mem_fault;

    mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .is_mem_inst  (is_mem_inst),
        .mem_write_en (mem_write_en),
        .is_word      (is_word),
        .halted       (halted),
        .alu_result   (alu_result),
        .read_data_2  (read_data_2),
        .cache_ready  (cache_ready),
        .cache_done   (cache_done),
        .cache_rdata  (cache_rdata),
        .cache_req    (cache_req),
        .cache_we     (cache_we),
        .cache_addr   (cache_addr),
        .cache_wdata  (cache_wdata),
        .cache_be     (cache_be),
        .mem_stall    (mem_stall),
        .mem_rdata    (mem_rdata),
        .mem_fault    (mem_fault)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
    } ret_t;

    req_t        q_req[$];
    ret_t        q_ret[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_load = 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares on every request handshake and every retirement.
    initial begin
        req_t er;
        ret_t et;
        forever begin
            @(negedge clk);
            if (rst_b) begin
                if (cache_req && cache_ready) begin
                    if (q_req.size() == 0) begin
                        check("unexpected_request", 32'd1, 32'd0);
                    end else begin
                        er = q_req.pop_front();
                        check("req_we", 32'(cache_we), 32'(er.we));
                        check("req_addr", cache_addr, er.addr);
                        check("req_be", 32'(cache_be), 32'(er.be));
                        if (er.we) check("req_wdata", cache_wdata, er.wdata);
                    end
                end
                if (is_mem_inst && !halted && !mem_stall) begin
                    if (q_ret.size() == 0) begin
                        check("unexpected_retire", 32'd1, 32'd0);
                    end else begin
                        et = q_ret.pop_front();
                        check("retire_fault", 32'(mem_fault), 32'(et.fault));
                        check("retire_rdata", mem_rdata, et.rdata);
                        if (et.fault) check("fault_req_low", 32'(cache_req), 32'd0);
                    end
                end else begin
                    check("no_spurious_fault", 32'(mem_fault), 32'd0);
                end
            end
        end
    end

    // One instruction. j counts cycles from the first REQ cycle; the cache asserts
    // ready at j==r and done at j==c. With tmo set, done never comes and the
    // instruction must fault at j==T-1.
    task automatic do_txn(input logic w, input logic we, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rd,
                          input int r, input int c, input bit tmo);
        int   off;
        int   last_j;
        req_t er;
        ret_t et;
        off          = int'(a[1:0]);
        is_mem_inst  = 1'b1;
        mem_write_en = we;
        is_word      = w;
        alu_result   = a;
        read_data_2  = sd;
        cache_ready  = 1'b0;
        cache_done   = 1'b0;
        if (w && off != 0) begin
            et.fault = 1'b1;
            et.rdata = last_load;
            q_ret.push_back(et);
            next_cycle();
            is_mem_inst = 1'b0;
            return;
        end
        if (r < T - 1) begin
            er.we    = we;
            er.addr  = a & 32'hFFFF_FFFC;
            er.be    = w ? 4'hF : 4'(1 << off);
            er.wdata = w ? sd : {4{sd[7:0]}};
            q_req.push_back(er);
        end
        if (tmo) begin
            et.fault = 1'b1;
            et.rdata = last_load;
        end else begin
            if (!we) last_load = w ? rd : ((rd >> (8 * off)) & 32'hFF);
            et.fault = 1'b0;
            et.rdata = last_load;
        end
        q_ret.push_back(et);
        last_j = tmo ? T - 1 : c;
        for (int j = 0; j <= last_j; j++) begin
            next_cycle();
            cache_ready = (j == r);
            cache_done  = !tmo && (j == c);
            cache_rdata = (!tmo && j == c) ? rd : $urandom;
        end
        next_cycle();
        is_mem_inst = 1'b0;
        cache_ready = 1'b0;
        cache_done  = 1'b0;
    endtask

    initial begin
        logic        w;
        logic        we;
        logic [31:0] a;
        int          r;
        int          c;
        bit          tmo;

        rst_b        = 1'b0;
        is_mem_inst  = 1'b0;
        mem_write_en = 1'b0;
        is_word      = 1'b0;
        halted       = 1'b0;
        alu_result   = 32'h0;
        read_data_2  = 32'h0;
        cache_ready  = 1'b0;
        cache_done   = 1'b0;
        cache_rdata  = 32'h0;

        repeat (2) next_cycle();
        rst_b = 1'b1;
        @(negedge clk);
        check("reset_req", 32'(cache_req), 32'd0);
        check("reset_stall", 32'(mem_stall), 32'd0);
        check("reset_fault", 32'(mem_fault), 32'd0);
        check("reset_rdata", mem_rdata, 32'h0);
        next_cycle();

        // Directed cases.
        do_txn(1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2, 1'b0);
        do_txn(1'b0, 1'b0, 32'h103, 32'h0, 32'hAABBCCDD, 0, 1, 1'b0);
        do_txn(1'b0, 1'b1, 32'h201, 32'h12345678, 32'h0, 1, 3, 1'b0);
        do_txn(1'b1, 1'b0, 32'h102, 32'h0, 32'h0, 0, 0, 1'b0);
        do_txn(1'b1, 1'b0, 32'h300, 32'h0, 32'h0, 100, 0, 1'b1);
        do_txn(1'b1, 1'b0, 32'h304, 32'h0, 32'h0, 2, 0, 1'b1);
        do_txn(1'b0, 1'b0, 32'h402, 32'h0, 32'h11223344, 1, 1, 1'b0);
        do_txn(1'b1, 1'b1, 32'h408, 32'hCAFEF00D, 32'h0, 0, 6, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            w  = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            a  = $urandom;
            if ($urandom_range(0, 9) == 0) begin
                tmo = 1'b1;
                r   = ($urandom_range(0, 1) == 0) ? 100 : int'($urandom_range(0, 5));
                c   = 0;
            end else begin
                tmo = 1'b0;
                r   = int'($urandom_range(0, 3));
                c   = ($urandom_range(0, 3) == 0) ? r : r + 1 + int'($urandom_range(0, 5 - r));
            end
            do_txn(w, we, a, $urandom, $urandom, r, c, tmo);
            repeat ($urandom_range(0, 2)) next_cycle();
        end

        // Reset while waiting on the cache; the late completion must be ignored.
        is_mem_inst  = 1'b1;
        mem_write_en = 1'b0;
        is_word      = 1'b1;
        alu_result   = 32'h500;
        begin
            req_t er;
            er.we = 1'b0; er.addr = 32'h500; er.be = 4'hF; er.wdata = 32'h0;
            q_req.push_back(er);
        end
        next_cycle();
        cache_ready = 1'b1;
        next_cycle();
        cache_ready = 1'b0;
        @(negedge clk);
        check("wait_stall", 32'(mem_stall), 32'd1);
        next_cycle();
        rst_b       = 1'b0;
        is_mem_inst = 1'b0;
        next_cycle();
        rst_b       = 1'b1;
        cache_done  = 1'b1;
        cache_rdata = 32'h55AA55AA;
        last_load   = 32'h0;
        @(negedge clk);
        check("post_reset_req", 32'(cache_req), 32'd0);
        check("post_reset_stall", 32'(mem_stall), 32'd0);
        check("post_reset_fault", 32'(mem_fault), 32'd0);
        check("post_reset_rdata", mem_rdata, 32'h0);
        next_cycle();
        cache_done = 1'b0;
        @(negedge clk);
        check("post_reset_rdata_held", mem_rdata, 32'h0);

        // Halted instruction: never requests or stalls, even misaligned.
        next_cycle();
        halted      = 1'b1;
        is_mem_inst = 1'b1;
        is_word     = 1'b1;
        alu_result  = 32'h600;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("halted_req", 32'(cache_req), 32'd0);
            check("halted_stall", 32'(mem_stall), 32'd0);
            next_cycle();
            alu_result = 32'h601;
        end
        halted      = 1'b0;
        is_mem_inst = 1'b0;

        // Instruction after the halt window still works.
        next_cycle();
        do_txn(1'b1, 1'b0, 32'h700, 32'h0, 32'h0BADCAFE, 0, 2, 1'b0);

        repeat (3) next_cycle();
        check("req_queue_empty", 32'(q_req.size()), 32'd0);
        check("retire_queue_empty", 32'(q_ret.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
